load_store_unit: RTL and testbench

Memory-stage controller between the pipeline's execute stage and `DataMemory`. It accepts one load or store request at a time over a valid/ready handshake and translates byte addresses into word addresses. It sequences the single-port, one-cycle-latency memory, including read-modify-write for sub-word stores, and returns load data or a fault to writeback.

---
 rtl/isa_mem_pkg.sv | 29 ++
 rtl/lsu_align.sv | 74 +++++++
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_mem_pkg.sv
// ============================================================================
// Module      : isa_mem_pkg
// Description : Shared types and constants for the memory stage: the
//               load/store controller state encoding, access-size codes and
//               DataMemory geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int MEM_DATA_W  = 32;
    localparam int MEM_WADDR_W = 14;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the load/store unit.
//               load_data : selected byte/half lane of rdata, zero- or
//                           sign-extended (word passes through).
//               merged    : rdata with wdata inserted into the selected lane
//                           (word store passes wdata through).
//               Ports: size, is_signed, lane (addr[1:0]), rdata, wdata in;
//                      load_data, merged out.
//               Sub-word lanes exist only when LSU_SUBWORD_EN is defined;
//               otherwise only the word-pass path is built.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import isa_mem_pkg::*;
(
    input  logic [1:0]            size,
    input  logic                  is_signed,
    input  logic [1:0]            lane,
    input  logic [MEM_DATA_W-1:0] rdata,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] load_data,
    output logic [MEM_DATA_W-1:0] merged
);

`ifdef LSU_SUBWORD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (lane)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = lane[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: load_data = {{16{is_signed & w_half[15]}}, w_half};
            default:   load_data = rdata;
        endcase

        merged = rdata;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end
`else
    logic w_unused_lane;

    assign load_data     = rdata;
    assign merged        = wdata;
    assign w_unused_lane = &{1'b0, size, is_signed, lane};
`endif

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage controller between execute and DataMemory.
//               Accepts one load/store at a time (valid/ready), checks for
//               faults at accept, drives the single-port one-cycle-latency
//               memory (read-modify-write for sub-word stores) and returns a
//               one-cycle response to writeback.
//               Ports: clk, rst (async, active-high);
//                      req_* request in, req_ready out;
//                      resp_* response out;
//                      mem_* strobes/address/write data out,
//                      mem_output_data in.
//               Build option: LSU_SUBWORD_EN enables byte/half accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import isa_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [MEM_DATA_W-1:0] req_wdata,
    input  logic [3:0]            req_rd,
    output logic                  resp_valid,
    output logic [MEM_DATA_W-1:0] resp_data,
    output logic [3:0]            resp_rd,
    output logic                  resp_fault,
    output logic                  mem_enable,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_W-3:0]     mem_address,
    output logic [MEM_DATA_W-1:0] mem_input_data,
    input  logic [MEM_DATA_W-1:0] mem_output_data
);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic                  r_write;
    logic                  r_signed;
    logic                  r_fault;
    logic [1:0]            r_size;
    logic [1:0]            r_lane;
    logic [ADDR_W-3:0]     r_waddr;
    logic [MEM_DATA_W-1:0] r_wdata;
    logic [MEM_DATA_W-1:0] r_rdata;
    logic [3:0]            r_rd;
    logic                  w_accept;
    logic                  w_fault;
    logic                  w_word_store;
    logic [MEM_DATA_W-1:0] w_load_data;
    logic [MEM_DATA_W-1:0] w_merged;

`ifdef LSU_SUBWORD_EN
    logic [MEM_DATA_W-1:0] r_merged;
`else
    logic                  w_unused_merge;
    assign w_unused_merge = &{1'b0, w_merged};
`endif

    assign w_accept     = req_valid & req_ready;
    assign w_word_store = r_write & (r_size == SIZE_WORD);

    // Fault classification on the raw request; only meaningful at accept.
    always_comb begin
        w_fault = (32'(req_addr[ADDR_W-1:2]) >= 32'(DEPTH_WORDS));
        case (req_size)
            SIZE_WORD: if (req_addr[1:0] != 2'b00) w_fault = 1'b1;
`ifdef LSU_SUBWORD_EN
            SIZE_HALF: if (req_addr[0]) w_fault = 1'b1;
            SIZE_BYTE: ;
`endif
            default:   w_fault = 1'b1;
        endcase
    end

    lsu_align u_align (
        .size      (r_size),
        .is_signed (r_signed),
        .lane      (r_lane),
        .rdata     (mem_output_data),
        .wdata     (r_wdata),
        .load_data (w_load_data),
        .merged    (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus all outputs, decoded from registered state only.
    always_comb begin
        w_next           = r_state;
        req_ready        = (r_state == ST_IDLE) & ~rst;
        resp_valid       = 1'b0;
        resp_data        = '0;
        resp_rd          = '0;
        resp_fault       = 1'b0;
        mem_enable       = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_input_data   = '0;
        mem_address      = (r_state != ST_IDLE) ? r_waddr : '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = w_fault ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_enable = 1'b1;
                if (w_word_store) begin
                    mem_write_enable = 1'b1;
                    mem_input_data   = r_wdata;
                    w_next           = ST_RESP;
                end else begin
                    mem_read_enable = 1'b1;
                    w_next          = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
`ifdef LSU_SUBWORD_EN
                w_next = r_write ? ST_WRITE : ST_RESP;
`else
                w_next = ST_RESP;
`endif
            end
`ifdef LSU_SUBWORD_EN
            ST_WRITE: begin
                mem_enable       = 1'b1;
                mem_write_enable = 1'b1;
                mem_input_data   = r_merged;
                w_next           = ST_RESP;
            end
`endif
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_data  = r_rdata;
                resp_rd    = r_rd;
                resp_fault = r_fault;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request fields are captured only on the accept edge; r_rdata is
    // cleared there so stores and faults answer with zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_lane   <= 2'b00;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_fault  <= 1'b0;
            r_rdata  <= '0;
`ifdef LSU_SUBWORD_EN
            r_merged <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_write  <= req_write;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_lane   <= req_addr[1:0];
                r_waddr  <= req_addr[ADDR_W-1:2];
                r_wdata  <= req_wdata;
                r_rd     <= req_rd;
                r_fault  <= w_fault;
                r_rdata  <= '0;
            end
            if (r_state == ST_CAPTURE && !r_write) r_rdata <= w_load_data;
`ifdef LSU_SUBWORD_EN
            if (r_state == ST_CAPTURE && r_write) r_merged <= w_merged;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: behavioural
//               DataMemory, reference memory image and response model,
//               directed and random requests, back-to-back and reset-abort
//               scenarios. Honours LSU_SUBWORD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_load_store_unit;
    import isa_mem_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_rd = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [3:0]  resp_rd;
    logic        resp_fault;
    logic        mem_enable;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [13:0] mem_address;
    logic [31:0] mem_input_data;
    logic [31:0] mem_output_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .resp_rd          (resp_rd),
        .resp_fault       (resp_fault),
        .mem_enable       (mem_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_input_data   (mem_input_data),
        .mem_output_data  (mem_output_data)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural DataMemory plus a bench-side preload port.
    logic [31:0] dmem [0:DEPTH-1];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) dmem[ld_addr] <= ld_data;
        if (mem_enable) begin
            if (mem_write_enable) dmem[mem_address[3:0]] <= mem_input_data;
            if (mem_read_enable)  mem_output_data <= dmem[mem_address[3:0]];
        end
    end

    // Strobe monitor.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [13:0] last_maddr = '0;

    always @(posedge clk) begin
        if (mem_enable | mem_read_enable | mem_write_enable) begin
            if (mem_read_enable)  rd_cnt++;
            if (mem_write_enable) wr_cnt++;
            last_maddr = mem_address;
            check_value("strobe_excl", {31'b0, mem_read_enable & mem_write_enable}, 32'd0);
            check_value("strobe_en", {31'b0, mem_enable}, {31'b0, mem_read_enable | mem_write_enable});
        end
    end

    // Reference model.
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] last_data;

    function automatic bit ref_fault(input bit [1:0] size, input bit [15:0] addr);
        if (int'(addr[15:2]) >= DEPTH) return 1'b1;
        if (size == 2'd2) return (addr[1:0] != 2'b00);
`ifdef LSU_SUBWORD_EN
        if (size == 2'd1) return addr[0];
        if (size == 2'd0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_value("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input bit wr, input bit [1:0] size, input bit sgn,
                          input bit [15:0] addr, input bit [31:0] wdata, input bit [3:0] rd);
        bit          flt;
        bit          got;
        int          exp_lat, lat, w, off, rd0, wr0, exp_rd, exp_wr;
        logic [31:0] exp_data, lanev, mask;
        flt      = ref_fault(size, addr);
        w        = int'(addr[15:2]);
        off      = int'(addr[1:0]);
        exp_data = 32'd0;
        if (flt)                     exp_lat = 1;
        else if (wr && size == 2'd2) exp_lat = 2;
        else if (wr)                 exp_lat = 4;
        else                         exp_lat = 3;
        if (!flt && !wr) begin
            lanev = ref_mem[w] >> (8 * off);
            if (size == 2'd0) begin
                exp_data = {24'b0, lanev[7:0]};
                if (sgn && lanev[7]) exp_data = exp_data - 32'd256;
            end else if (size == 2'd1) begin
                exp_data = {16'b0, lanev[15:0]};
                if (sgn && lanev[15]) exp_data = exp_data - 32'd65536;
            end else begin
                exp_data = lanev;
            end
        end
        exp_rd = (!flt && !(wr && size == 2'd2)) ? 1 : 0;
        exp_wr = (!flt && wr) ? 1 : 0;

        wait_ready();
        rd0        = rd_cnt;
        wr0        = wr_cnt;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_addr   = 16'($urandom);
        req_wdata  = $urandom;
        req_rd     = 4'($urandom);

        lat = 0;
        got = 1'b0;
        while (lat < 10 && !got) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        check_value("resp_seen", {31'b0, got}, 32'd1);
        if (got) begin
            last_data = resp_data;
            check_value("latency", 32'(lat), 32'(exp_lat));
            check_value("resp_data", resp_data, exp_data);
            check_value("resp_fault", {31'b0, resp_fault}, {31'b0, flt});
            check_value("resp_rd", {28'b0, resp_rd}, {28'b0, rd});
            check_value("ready_in_resp", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            check_value("resp_pulse", {31'b0, resp_valid}, 32'd0);
            check_value("ready_after", {31'b0, req_ready}, 32'd1);
        end

        if (!flt && wr) begin
            if (size == 2'd0)      mask = 32'h0000_00FF;
            else if (size == 2'd1) mask = 32'h0000_FFFF;
            else                   mask = 32'hFFFF_FFFF;
            mask       = mask << (8 * off);
            ref_mem[w] = (ref_mem[w] & ~mask) | ((wdata << (8 * off)) & mask);
        end
        check_value("n_reads", 32'(rd_cnt - rd0), 32'(exp_rd));
        check_value("n_writes", 32'(wr_cnt - wr0), 32'(exp_wr));
        if (!flt) begin
            check_value("strobe_addr", {18'b0, last_maddr}, 32'(w));
            check_value("mem_word", dmem[w], ref_mem[w]);
        end
    endtask

    task automatic back_to_back(input bit [15:0] a0, input bit [15:0] a1);
        int n;
        bit got;
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = SIZE_WORD;
        req_addr  = a0;
        req_rd    = 4'd3;
        @(posedge clk);
        #1;
        req_addr  = a1;
        req_rd    = 4'd9;
        n = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (resp_valid) got = 1'b1;
        end
        check_value("b2b_lat0", 32'(n), 32'd3);
        check_value("b2b_data0", resp_data, ref_mem[a0[15:2]]);
        check_value("b2b_rd0", {28'b0, resp_rd}, 32'd3);
        n = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            n++;
            if (resp_valid) got = 1'b1;
        end
        req_valid = 1'b0;
        check_value("b2b_gap", 32'(n), 32'd4);
        check_value("b2b_data1", resp_data, ref_mem[a1[15:2]]);
        check_value("b2b_rd1", {28'b0, resp_rd}, 32'd9);
        @(negedge clk);
    endtask

    task automatic reset_mid_write(input bit [1:0] size, input bit [15:0] addr, input bit [31:0] wdata);
        bit found = 1'b0;
        int w;
        w = int'(addr[15:2]);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = 4'd6;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_write_enable) begin
                found = 1'b1;
                break;
            end
        end
        check_value("rst_found_write", {31'b0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check_value("rst_ctl", {26'b0, resp_valid, resp_fault, mem_enable, mem_read_enable,
                                mem_write_enable, req_ready}, 32'd0);
        check_value("rst_resp_data", resp_data, 32'd0);
        check_value("rst_mem_wdata", mem_input_data, 32'd0);
        check_value("rst_mem_addr", {18'b0, mem_address}, 32'd0);
        check_value("rst_resp_rd", {28'b0, resp_rd}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_no_resp", {31'b0, resp_valid}, 32'd0);
        check_value("rst_ready", {31'b0, req_ready}, 32'd1);
        check_value("rst_mem_kept", dmem[w], ref_mem[w]);
    endtask

    initial begin
        // Preload memory while reset is held.
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            ld_en      = 1'b1;
            ld_addr    = 4'(i);
            ld_data    = $urandom;
            ref_mem[i] = ld_data;
            @(negedge clk);
        end
        ld_en = 1'b0;

        check_value("reset_ready", {31'b0, req_ready}, 32'd0);
        check_value("reset_ctl", {27'b0, resp_valid, resp_fault, mem_enable, mem_read_enable,
                                  mem_write_enable}, 32'd0);
        check_value("reset_data", resp_data, 32'd0);
        check_value("reset_maddr", {18'b0, mem_address}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_value("ready_post_reset", {31'b0, req_ready}, 32'd1);

        // Word store then word load.
        do_req(1'b1, SIZE_WORD, 1'b0, 16'h0008, 32'hDEAD_BEEF, 4'd5);
        check_value("st_word_data0", last_data, 32'd0);
        check_value("mem2_deadbeef", dmem[2], 32'hDEAD_BEEF);
        do_req(1'b0, SIZE_WORD, 1'b0, 16'h0008, 32'd0, 4'd7);
        check_value("ld_deadbeef", last_data, 32'hDEAD_BEEF);

`ifdef LSU_SUBWORD_EN
        do_req(1'b1, SIZE_WORD, 1'b0, 16'h0004, 32'h1122_3344, 4'd1);
        do_req(1'b1, SIZE_BYTE, 1'b0, 16'h0006, 32'h0000_00AA, 4'd2);
        check_value("mem1_merged", dmem[1], 32'h11AA_3344);
        do_req(1'b0, SIZE_BYTE, 1'b1, 16'h0006, 32'd0, 4'd3);
        check_value("ld_byte_s", last_data, 32'hFFFF_FFAA);
        do_req(1'b0, SIZE_BYTE, 1'b0, 16'h0006, 32'd0, 4'd4);
        check_value("ld_byte_u", last_data, 32'h0000_00AA);
`else
        do_req(1'b0, SIZE_BYTE, 1'b0, 16'h0004, 32'd0, 4'd4);
`endif
        do_req(1'b0, SIZE_HALF, 1'b1, 16'h0005, 32'd0, 4'd8);
        do_req(1'b0, SIZE_WORD, 1'b0, 16'h0040, 32'd0, 4'd9);
        do_req(1'b0, 2'b11,     1'b0, 16'h0000, 32'd0, 4'd10);

        back_to_back(16'h0008, 16'h000C);

        for (int k = 0; k < 60; k++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom),
                   16'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3)),
                   $urandom, 4'($urandom));
        end

`ifdef LSU_SUBWORD_EN
        reset_mid_write(SIZE_BYTE, 16'h0006, 32'h0000_0055);
`else
        reset_mid_write(SIZE_WORD, 16'h0008, 32'h0BAD_F00D);
`endif
        do_req(1'b0, SIZE_WORD, 1'b0, 16'h0008, 32'd0, 4'd11);

        for (int i = 0; i < DEPTH; i++) check_value("final_mem", dmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
